// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver: FSM states, parity modes, counter widths.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Width of a counter holding values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_maj3.sv
// Three-sample majority voter: two registered RX samples plus the live sample.
// The vote is meaningful on the edge where the caller asserts i_vote_en (s = MID+1).
module uart_maj3 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rx,
    input  logic i_vote_en,
    output logic o_vote_vld,
    output logic o_vote
);

    logic [1:0] r_hist;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], i_rx};
        end
    end

    assign o_vote     = (r_hist[1] & r_hist[0]) | (r_hist[1] & i_rx) | (r_hist[0] & i_rx);
    assign o_vote_vld = i_vote_en;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable oversampling UART receiver with majority vote, parity and framing checks.
// Optional break detection is compiled in with UART_RX_BREAK_EN.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] DATA,
    output logic                 STROBE,
    output logic                 PAR_ERR,
    output logic                 FRM_ERR
`ifdef UART_RX_BREAK_EN
    ,
    output logic                 BREAK
`endif
);

    localparam int SW  = cnt_w(OVERSAMPLE);
    localparam int BW  = cnt_w(DATA_BITS + 1);
    localparam int MID = OVERSAMPLE / 2;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SW-1:0]         r_s;
    logic [BW-1:0]         r_bit_cnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_par_bit;
    logic                  r_stop_bad;
    logic [DATA_BITS-1:0]  r_data;
    logic                  r_strobe;
    logic                  r_par_err;
    logic                  r_frm_err;

    logic                  w_mid1;
    logic                  w_last_s;
    logic                  w_vote_en;
    logic                  w_vote_vld;
    logic                  w_vote;
    logic                  w_bits_done;
    logic                  w_frame_done;
    logic                  w_frm_fin;
    logic                  w_par_fin;
    logic                  w_brk_hold;

    assign w_mid1    = (r_s == SW'(MID + 1));
    assign w_last_s  = (r_s == SW'(OVERSAMPLE - 1));
    assign w_vote_en = (r_state != S_IDLE) && w_mid1;

    uart_maj3 u_maj3 (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_rx       (RX),
        .i_vote_en  (w_vote_en),
        .o_vote_vld (w_vote_vld),
        .o_vote     (w_vote)
    );

    // With OVERSAMPLE=4 the vote and the bit's last sample share an edge, so count the bit in flight.
    assign w_bits_done = (r_bit_cnt == BW'(DATA_BITS)) ||
                         (w_vote_vld && (r_bit_cnt == BW'(DATA_BITS - 1)));

    always_comb begin
        w_state_nxt  = r_state;
        w_frame_done = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!RX && !w_brk_hold) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_vote_vld && w_vote) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last_s) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_last_s && w_bits_done) begin
                    w_state_nxt = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_last_s) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_vote_vld && (r_bit_cnt == BW'(STOP_BITS - 1))) begin
                    w_state_nxt  = S_IDLE;
                    w_frame_done = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The start-detect cycle is sample 0, so the first START cycle is sample 1.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_s <= '0;
        end else if (r_state == S_IDLE) begin
            r_s <= (w_state_nxt == S_START) ? SW'(1) : '0;
        end else if (w_state_nxt == S_IDLE || w_last_s) begin
            r_s <= '0;
        end else begin
            r_s <= r_s + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_bit_cnt <= '0;
        end else if (r_state != w_state_nxt) begin
            r_bit_cnt <= '0;
        end else if (w_vote_vld && (r_state == S_DATA || r_state == S_STOP)) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            r_stop_bad <= 1'b0;
        end else begin
            if (r_state == S_START) begin
                r_stop_bad <= 1'b0;
            end
            if (w_vote_vld) begin
                if (r_state == S_DATA) begin
                    r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                end
                if (r_state == S_PARITY) begin
                    r_par_bit <= w_vote;
                end
                if (r_state == S_STOP && !w_vote) begin
                    r_stop_bad <= 1'b1;
                end
            end
        end
    end

    assign w_frm_fin = r_stop_bad | ~w_vote;

    always_comb begin
        w_par_fin = 1'b0;
        if (PARITY == PAR_EVEN) begin
            w_par_fin = (^r_shift) ^ r_par_bit;
        end else if (PARITY == PAR_ODD) begin
            w_par_fin = ~((^r_shift) ^ r_par_bit);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_data    <= '0;
            r_strobe  <= 1'b0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
        end else begin
            r_strobe <= w_frame_done;
            if (w_frame_done) begin
                r_data    <= r_shift;
                r_par_err <= w_par_fin;
                r_frm_err <= w_frm_fin;
            end
        end
    end

    assign DATA    = r_data;
    assign STROBE  = r_strobe;
    assign PAR_ERR = r_par_err;
    assign FRM_ERR = r_frm_err;

`ifdef UART_RX_BREAK_EN
    logic          r_break;
    logic [SW-1:0] r_brk_cnt;

    // Break holds the receiver in IDLE until one full bit time of consecutive idle samples.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_break   <= 1'b0;
            r_brk_cnt <= '0;
        end else if (w_frame_done && w_frm_fin && (r_shift == '0)) begin
            r_break   <= 1'b1;
            r_brk_cnt <= '0;
        end else if (r_break) begin
            if (!RX) begin
                r_brk_cnt <= '0;
            end else if (r_brk_cnt == SW'(OVERSAMPLE - 1)) begin
                r_break   <= 1'b0;
                r_brk_cnt <= '0;
            end else begin
                r_brk_cnt <= r_brk_cnt + 1'b1;
            end
        end
    end

    assign w_brk_hold = r_break;
    assign BREAK      = r_break;
`else
    assign w_brk_hold = 1'b0;
`endif

endmodule
